// File: rtl/truth_table_bist_pkg.sv
// rtl/truth_table_bist_pkg.sv - shared state encodings and sizing helper for the truth-table BIST
package truth_table_bist_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter width needed to reach HOLD-1; never narrower than one bit.
    function automatic int hold_width(input int hold);
        return (hold <= 2) ? 1 : $clog2(hold);
    endfunction

endpackage

// File: rtl/truth_table_bist_if.sv
// rtl/truth_table_bist_if.sv - stimulus/response and result signals between the BIST and its user
interface truth_table_bist_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic            f_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            fail_seen;

    modport master (
        input  start, f_in,
        output vec_out, busy, done, pass, err_count, first_fail, fail_seen
    );

    modport slave (
        output start, f_in,
        input  vec_out, busy, done, pass, err_count, first_fail, fail_seen
    );
endinterface

// File: rtl/truth_table_bist_hold_timer.sv
// rtl/truth_table_bist_hold_timer.sv - per-vector hold counter with terminal-count pulse at HOLD-1
module hold_timer
    import truth_table_bist_pkg::*;
#(
    parameter int HOLD = 20,
    parameter int TW   = hold_width(HOLD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    output logic [TW-1:0] count,
    output logic          tc
);
    localparam logic [TW-1:0] LAST = TW'(HOLD - 1);

    assign tc = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/truth_table_bist.sv
// rtl/truth_table_bist.sv - exhaustive stimulus generator and truth-table checker for a small combinational DUT
module truth_table_bist
    import truth_table_bist_pkg::*;
#(
    parameter int                    N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = 16'hF888,
    parameter int                    HOLD     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    truth_table_bist_if.master bus
);
    localparam int              TW       = hold_width(HOLD);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    logic [1:0]      state;
    logic [N_IN-1:0] vec;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic [N_IN:0]   err_r;
    logic [N_IN-1:0] ff_r;
    logic            fs_r;
    logic [TW-1:0]   timer;
    logic            tc;
    logic            running;
    logic            mism;

    assign running = (state == ST_RUN);

    // An undriven DUT output must never look like a match in simulation.
`ifdef SYNTHESIS
    assign mism = (bus.f_in != EXPECTED[vec]);
`else
    assign mism = (bus.f_in !== EXPECTED[vec]);
`endif

    hold_timer #(
        .HOLD (HOLD),
        .TW   (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!running),
        .en    (running),
        .count (timer),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            vec    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= '0;
            ff_r   <= '0;
            fs_r   <= 1'b0;
        end else if (state == ST_RUN) begin
            if (tc) begin
                if (mism) begin
                    err_r <= err_r + 1'b1;
                    if (!fs_r) begin
                        ff_r <= vec;
                        fs_r <= 1'b1;
                    end
                end
                if (vec == LAST_VEC) begin
                    state  <= ST_DONE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    pass_r <= (err_r == '0) && !mism;
                end else begin
                    vec <= vec + 1'b1;
                end
            end
        end else if (bus.start) begin
            state  <= ST_RUN;
            vec    <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= '0;
            ff_r   <= '0;
            fs_r   <= 1'b0;
        end
    end

    assign bus.vec_out    = vec;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.err_count  = err_r;
    assign bus.first_fail = ff_r;
    assign bus.fail_seen  = fs_r;
endmodule

// File: tb/tb_truth_table_bist.sv
// tb/tb_truth_table_bist.sv - scoreboard bench: default BIST plus a short N_IN=2/HOLD=2 instance
module tb_truth_table_bist;

    typedef struct {
        int e0;
        int total;
        int hold;
        int last;
        int err;
        int ff;
        int fs;
        int pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [15:0] tt0;
    logic [3:0]  tt1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       sbq[2][$];

    truth_table_bist_if #(.N_IN(4)) bus0();
    truth_table_bist_if #(.N_IN(2)) bus1();

    truth_table_bist #(.N_IN(4), .EXPECTED(16'hF888), .HOLD(20)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    truth_table_bist #(.N_IN(2), .EXPECTED(4'b1000), .HOLD(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    // Models of the combinational DUT each BIST is attached to.
    assign bus0.f_in = tt0[bus0.vec_out];
    assign bus1.f_in = tt1[bus1.vec_out];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected result of one run, from the truth tables alone.
    function automatic exp_t model(input int nin, input int hold, input logic [15:0] expv,
                                   input logic [15:0] ttv, input int e0);
        exp_t m;
        m.e0 = e0; m.hold = hold; m.total = (1 << nin) * hold; m.last = (1 << nin) - 1;
        m.err = 0; m.ff = 0; m.fs = 0;
        for (int v = 0; v < (1 << nin); v++) begin
            if (ttv[v] !== expv[v]) begin
                m.err++;
                if (m.fs == 0) begin
                    m.fs = 1;
                    m.ff = v;
                end
            end
        end
        m.pass = (m.err == 0) ? 1 : 0;
        return m;
    endfunction

    task automatic mon(input int d, input int busy, input int done, input int pass,
                       input int fs, input int err, input int vec, input int ff);
        exp_t e;
        int   t;
        if (sbq[d].size() == 0) return;
        e = sbq[d][0];
        if (cyc < e.e0) return;
        t = cyc - e.e0;
        if (t < e.total) begin
            if (t == 0) begin
                chk($sformatf("d%0d_err_cleared", d), err, 0);
                chk($sformatf("d%0d_fs_cleared", d), fs, 0);
                chk($sformatf("d%0d_done_cleared", d), done, 0);
            end
            if (t % e.hold == 0) begin
                chk($sformatf("d%0d_busy", d), busy, 1);
                chk($sformatf("d%0d_vec", d), vec, t / e.hold);
            end
        end else begin
            chk($sformatf("d%0d_done", d), done, 1);
            chk($sformatf("d%0d_busy_end", d), busy, 0);
            chk($sformatf("d%0d_err_count", d), err, e.err);
            chk($sformatf("d%0d_first_fail", d), ff, e.ff);
            chk($sformatf("d%0d_fail_seen", d), fs, e.fs);
            chk($sformatf("d%0d_pass", d), pass, e.pass);
            chk($sformatf("d%0d_vec_end", d), vec, e.last);
            void'(sbq[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, int'(bus0.busy), int'(bus0.done), int'(bus0.pass), int'(bus0.fail_seen),
            int'(bus0.err_count), int'(bus0.vec_out), int'(bus0.first_fail));
        mon(1, int'(bus1.busy), int'(bus1.done), int'(bus1.pass), int'(bus1.fail_seen),
            int'(bus1.err_count), int'(bus1.vec_out), int'(bus1.first_fail));
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_d0_vec"}, int'(bus0.vec_out), 0);
        chk({nm, "_d0_busy"}, int'(bus0.busy), 0);
        chk({nm, "_d0_done"}, int'(bus0.done), 0);
        chk({nm, "_d0_pass"}, int'(bus0.pass), 0);
        chk({nm, "_d0_err"}, int'(bus0.err_count), 0);
        chk({nm, "_d0_ff"}, int'(bus0.first_fail), 0);
        chk({nm, "_d0_fs"}, int'(bus0.fail_seen), 0);
        chk({nm, "_d1_vec"}, int'(bus1.vec_out), 0);
        chk({nm, "_d1_busy"}, int'(bus1.busy), 0);
        chk({nm, "_d1_err"}, int'(bus1.err_count), 0);
    endtask

    task automatic wait_empty(input int d, input int budget);
        int i = 0;
        while (sbq[d].size() > 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_chk++;
        if (sbq[d].size() > 0) begin
            n_fail++;
            $display("FAIL d%0d_timeout: %0d runs still pending after %0d cycles", d, sbq[d].size(), budget);
            sbq[d].delete();
        end
    endtask

    task automatic run0(input logic [15:0] tt, input int pulse_at);
        @(negedge clk);
        tt0 = tt;
        bus0.start = 1'b1;
        sbq[0].push_back(model(4, 20, 16'hF888, tt, cyc + 1));
        @(negedge clk);
        bus0.start = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at - 1) @(negedge clk);
            bus0.start = 1'b1;
            @(negedge clk);
            bus0.start = 1'b0;
        end
        wait_empty(0, 1000);
    endtask

    task automatic run1_held(input logic [3:0] tt);
        int e0;
        int i;
        @(negedge clk);
        tt1 = tt;
        bus1.start = 1'b1;
        e0 = cyc + 1;
        sbq[1].push_back(model(2, 2, 16'h0008, {12'h000, tt}, e0));
        sbq[1].push_back(model(2, 2, 16'h0008, {12'h000, tt}, e0 + 9));
        i = 0;
        while (cyc < e0 + 10 && i < 100) begin
            @(negedge clk);
            i++;
        end
        bus1.start = 1'b0;
        wait_empty(1, 200);
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        tt0 = 16'hF888;
        tt1 = 4'h8;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        run0(16'hF888, 0);
        run0(16'hF000, 0);
        run0(16'hFFFF, 0);
        run0(16'hF888, 100);
        for (int r = 0; r < 4; r++) begin
            run0(16'($urandom), (r % 2 == 1) ? int'($urandom_range(1, 300)) : 0);
        end

        // Abort a failing run at vector 7; nothing of it may survive.
        @(negedge clk);
        tt0 = 16'hFFFF;
        bus0.start = 1'b1;
        sbq[0].push_back(model(4, 20, 16'hF888, 16'hFFFF, cyc + 1));
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (7 * 20 + 5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        #1;
        chk_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run0(16'hF888, 0);

        run1_held(4'h8);
        for (int r = 0; r < 3; r++) begin
            run1_held(4'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
